// File: rtl/axis_ramp_checker.sv
// axis_ramp_checker: AXI-Stream sink that checks every packet against an
// arithmetic ramp (start + idx*inc) and an expected beat count. It counts
// packets and errored packets and captures the first error since reset/clear.
module axis_ramp_checker #(
  parameter int DWIDTH = 64,
  parameter int LWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DWIDTH-1:0] cfg_ramp_start,
  input  logic [DWIDTH-1:0] cfg_ramp_inc,
  input  logic [LWIDTH-1:0] cfg_pkt_len,
  input  logic [3:0]        cfg_throttle,
  input  logic [DWIDTH-1:0] i_tdata,
  input  logic              i_tvalid,
  input  logic              i_tlast,
  output logic              i_tready,
  output logic [31:0]       pkt_count,
  output logic [31:0]       err_count,
  output logic              pkt_done,
  output logic              err_flag,
  output logic [1:0]        err_type,
  output logic [DWIDTH-1:0] err_data,
  output logic [LWIDTH-1:0] err_idx
);

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_BODY   = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  localparam logic [31:0]       CNT_MAX   = 32'hFFFF_FFFF;
  localparam logic [LWIDTH-1:0] LEN_ONE   = 1;
  localparam logic [1:0]        E_DATA    = 2'b01;
  localparam logic [1:0]        E_EARLY   = 2'b10;
  localparam logic [1:0]        E_MISSING = 2'b11;

  state_t            state_q;
  logic [3:0]        thr_cnt_q;
  logic              tready_q;
  logic [LWIDTH-1:0] idx_q;
  logic [LWIDTH-1:0] len_q;
  logic [DWIDTH-1:0] exp_q;
  logic [DWIDTH-1:0] inc_q;
  logic              pkt_err_q;
  logic [31:0]       pkt_count_q;
  logic [31:0]       err_count_q;
  logic              pkt_done_q;
  logic              err_flag_q;
  logic [1:0]        err_type_q;
  logic [DWIDTH-1:0] err_data_q;
  logic [LWIDTH-1:0] err_idx_q;

  logic              accept;
  logic              first;
  logic              checking;
  logic [LWIDTH-1:0] cur_idx;
  logic [LWIDTH-1:0] cur_len;
  logic [DWIDTH-1:0] cur_exp;
  logic [DWIDTH-1:0] cur_inc;
  logic [DWIDTH-1:0] exp_d;
  logic [LWIDTH-1:0] idx_d;
  logic              data_err;
  logic              early_err;
  logic              missing_err;
  logic              beat_err;
  logic [1:0]        beat_err_type;

  assign accept = i_tvalid && tready_q;

  // Backpressure: free-running 4-bit phase counter, ready registered from it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_cnt_q <= 4'd0;
      tready_q  <= 1'b0;
    end else begin
      tready_q  <= (thr_cnt_q >= cfg_throttle);
      thr_cnt_q <= clear ? 4'd0 : thr_cnt_q + 4'd1;
    end
  end

  // Expectation for the beat on the bus; beat 0 uses the live config directly
  always_comb begin
    first       = (state_q == S_FIRST);
    checking    = (state_q != S_RESYNC);
    cur_idx     = first ? '0 : idx_q;
    cur_len     = first ? ((cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len) : len_q;
    cur_exp     = first ? cfg_ramp_start : exp_q;
    cur_inc     = first ? cfg_ramp_inc : inc_q;
    exp_d       = cur_exp + cur_inc;
    idx_d       = cur_idx + LEN_ONE;
    data_err    = (i_tdata != cur_exp);
    early_err   = i_tlast && (cur_idx < cur_len - LEN_ONE);
    missing_err = !i_tlast && (cur_idx == cur_len - LEN_ONE);
    beat_err    = checking && (data_err || early_err || missing_err);
    if (data_err) begin
      beat_err_type = E_DATA;
    end else if (early_err) begin
      beat_err_type = E_EARLY;
    end else begin
      beat_err_type = E_MISSING;
    end
  end

  // Packet FSM, saturating counters and first-error capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FIRST;
      idx_q       <= '0;
      len_q       <= LEN_ONE;
      exp_q       <= '0;
      inc_q       <= '0;
      pkt_err_q   <= 1'b0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      pkt_done_q  <= 1'b0;
      err_flag_q  <= 1'b0;
      err_type_q  <= 2'b00;
      err_data_q  <= '0;
      err_idx_q   <= '0;
    end else if (clear) begin
      state_q     <= S_FIRST;
      idx_q       <= '0;
      len_q       <= LEN_ONE;
      exp_q       <= '0;
      inc_q       <= '0;
      pkt_err_q   <= 1'b0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      pkt_done_q  <= 1'b0;
      err_flag_q  <= 1'b0;
      err_type_q  <= 2'b00;
      err_data_q  <= '0;
      err_idx_q   <= '0;
    end else begin
      pkt_done_q <= accept && i_tlast;
      if (accept) begin
        if (first) begin
          len_q <= cur_len;
          inc_q <= cur_inc;
        end
        if (beat_err && !err_flag_q) begin
          err_flag_q <= 1'b1;
          err_type_q <= beat_err_type;
          err_data_q <= i_tdata;
          err_idx_q  <= cur_idx;
        end
        if (i_tlast) begin
          state_q   <= S_FIRST;
          idx_q     <= '0;
          pkt_err_q <= 1'b0;
          if (pkt_count_q != CNT_MAX) begin
            pkt_count_q <= pkt_count_q + 32'd1;
          end
          if ((pkt_err_q || beat_err) && (err_count_q != CNT_MAX)) begin
            err_count_q <= err_count_q + 32'd1;
          end
        end else if (beat_err) begin
          state_q   <= S_RESYNC;
          pkt_err_q <= 1'b1;
        end else if (checking) begin
          state_q <= S_BODY;
          idx_q   <= idx_d;
          exp_q   <= exp_d;
        end
      end
    end
  end

  assign i_tready  = tready_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
  assign pkt_done  = pkt_done_q;
  assign err_flag  = err_flag_q;
  assign err_type  = err_type_q;
  assign err_data  = err_data_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_axis_ramp_checker.sv
// tb_axis_ramp_checker: directed and randomized packets against a packet-level
// reference model (beat queue rescanned with start + i*inc arithmetic).
module tb_axis_ramp_checker;

  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [DW-1:0] cfg_ramp_start;
  logic [DW-1:0] cfg_ramp_inc;
  logic [LW-1:0] cfg_pkt_len;
  logic [3:0]    cfg_throttle;
  logic [DW-1:0] i_tdata;
  logic          i_tvalid;
  logic          i_tlast;
  logic          i_tready;
  logic [31:0]   pkt_count;
  logic [31:0]   err_count;
  logic          pkt_done;
  logic          err_flag;
  logic [1:0]    err_type;
  logic [DW-1:0] err_data;
  logic [LW-1:0] err_idx;

  int nChecks = 0;
  int nFail = 0;
  int doneCount = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  // reference model state
  beat_t         beatQ[$];
  int            mThr;
  bit            mRdy;
  bit            mDone;
  logic [DW-1:0] mStart;
  logic [DW-1:0] mInc;
  int            mLen;
  logic [31:0]   mPkt;
  logic [31:0]   mErr;
  bit            mFlag;
  logic [1:0]    mType;
  logic [DW-1:0] mErrData;
  logic [LW-1:0] mErrIdx;

  always #5 clk = ~clk;

  axis_ramp_checker #(.DWIDTH(DW), .LWIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .cfg_ramp_start (cfg_ramp_start),
    .cfg_ramp_inc   (cfg_ramp_inc),
    .cfg_pkt_len    (cfg_pkt_len),
    .cfg_throttle   (cfg_throttle),
    .i_tdata        (i_tdata),
    .i_tvalid       (i_tvalid),
    .i_tlast        (i_tlast),
    .i_tready       (i_tready),
    .pkt_count      (pkt_count),
    .err_count      (err_count),
    .pkt_done       (pkt_done),
    .err_flag       (err_flag),
    .err_type       (err_type),
    .err_data       (err_data),
    .err_idx        (err_idx)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    beatQ.delete();
    mThr = 0; mRdy = 0; mDone = 0;
    mStart = '0; mInc = '0; mLen = 1;
    mPkt = '0; mErr = '0; mFlag = 0; mType = 2'b00; mErrData = '0; mErrIdx = '0;
  endfunction

  // first error of the packet so far: index and code, or -1
  function automatic void scanPacket(output int errIdx, output logic [1:0] errType);
    errIdx = -1;
    errType = 2'b00;
    for (int i = 0; i < beatQ.size(); i++) begin
      logic [DW-1:0] want;
      want = mStart + mInc * DW'(i);
      if (beatQ[i].data !== want) begin
        errIdx = i; errType = 2'b01; return;
      end
      if (beatQ[i].last && (i < mLen - 1)) begin
        errIdx = i; errType = 2'b10; return;
      end
      if (!beatQ[i].last && (i == mLen - 1)) begin
        errIdx = i; errType = 2'b11; return;
      end
    end
  endfunction

  // one rising edge of the model, fed with the inputs the DUT sees
  function automatic void modelEdge();
    int         eIdx;
    logic [1:0] eType;
    bit         acc;
    beat_t      b;
    if (reset) return;
    acc = i_tvalid && mRdy;
    mDone = 0;
    if (clear) begin
      beatQ.delete();
      mPkt = '0; mErr = '0; mFlag = 0; mType = 2'b00; mErrData = '0; mErrIdx = '0;
    end else if (acc) begin
      if (beatQ.size() == 0) begin
        mStart = cfg_ramp_start;
        mInc   = cfg_ramp_inc;
        mLen   = (cfg_pkt_len == '0) ? 1 : int'(cfg_pkt_len);
      end
      b.data = i_tdata;
      b.last = i_tlast;
      beatQ.push_back(b);
      scanPacket(eIdx, eType);
      if (eIdx >= 0 && !mFlag) begin
        mFlag = 1; mType = eType; mErrData = beatQ[eIdx].data; mErrIdx = LW'(eIdx);
      end
      if (i_tlast) begin
        if (mPkt != 32'hFFFF_FFFF) mPkt = mPkt + 32'd1;
        if (eIdx >= 0 && mErr != 32'hFFFF_FFFF) mErr = mErr + 32'd1;
        mDone = 1;
        beatQ.delete();
      end
    end
    mRdy = (mThr >= int'(cfg_throttle));
    mThr = clear ? 0 : (mThr + 1) % 16;
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if (!reset) begin
      checkOutput("tready", 64'(i_tready), 64'(mRdy));
      checkOutput("pkt_done", 64'(pkt_done), 64'(mDone));
      if (pkt_done === 1'b1) doneCount++;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".pkt_count"}, 64'(pkt_count), 64'(mPkt));
    checkOutput({tag, ".err_count"}, 64'(err_count), 64'(mErr));
    checkOutput({tag, ".err_flag"}, 64'(err_flag), 64'(mFlag));
    checkOutput({tag, ".err_type"}, 64'(err_type), 64'(mType));
    checkOutput({tag, ".err_data"}, 64'(err_data), 64'(mErrData));
    checkOutput({tag, ".err_idx"}, 64'(err_idx), 64'(mErrIdx));
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
    int waited;
    waited = 0;
    i_tdata  = data;
    i_tlast  = last;
    i_tvalid = 1'b1;
    while (!mRdy && waited < 32) begin
      tick();
      waited++;
    end
    if (!mRdy) begin
      nChecks++;
      nFail++;
      $error("[TB] FAIL accept_timeout observed=not_ready expected=ready");
    end
    tick();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic sendPacket(input int nBeats, input int badIdx, input int maxGap);
    logic [DW-1:0] d;
    for (int k = 0; k < nBeats; k++) begin
      d = cfg_ramp_start + cfg_ramp_inc * DW'(k);
      if (k == badIdx) d = d ^ 64'h1;
      applyStimulus(d, k == nBeats - 1);
      repeat ($urandom_range(0, maxGap)) tick();
    end
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic setCfg(input logic [DW-1:0] s, input logic [DW-1:0] inc, input int len, input int thr);
    cfg_ramp_start = s;
    cfg_ramp_inc   = inc;
    cfg_pkt_len    = LW'(len);
    cfg_throttle   = 4'(thr);
  endtask

  initial begin
    int doneBase;
    int accCount;
    int k;

    reset = 1'b1; clear = 1'b0;
    i_tvalid = 1'b0; i_tdata = '0; i_tlast = 1'b0;
    setCfg(64'h10, 64'h2, 4, 0);
    modelReset();
    @(negedge clk);
    tick();
    tick();
    checkOutput("reset.tready", 64'(i_tready), 64'd0);
    checkOutput("reset.pkt_count", 64'(pkt_count), 64'd0);
    checkOutput("reset.err_count", 64'(err_count), 64'd0);
    checkOutput("reset.pkt_done", 64'(pkt_done), 64'd0);
    checkOutput("reset.err_flag", 64'(err_flag), 64'd0);
    checkOutput("reset.err_type", 64'(err_type), 64'd0);
    checkOutput("reset.err_data", 64'(err_data), 64'd0);
    checkOutput("reset.err_idx", 64'(err_idx), 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("ready_after_reset", 64'(i_tready), 64'd1);

    // good ramp packet
    doneBase = doneCount;
    sendPacket(4, -1, 0);
    tick(); tick();
    checkModel("good");
    checkOutput("good.pkt_count", 64'(pkt_count), 64'd1);
    checkOutput("good.err_count", 64'(err_count), 64'd0);
    checkOutput("good.err_flag", 64'(err_flag), 64'd0);
    checkOutput("good.done_pulses", 64'(doneCount - doneBase), 64'd1);

    // data mismatch on beat 2
    doClear();
    applyStimulus(64'h10, 1'b0);
    applyStimulus(64'h12, 1'b0);
    applyStimulus(64'hFF, 1'b0);
    applyStimulus(64'h16, 1'b1);
    tick(); tick();
    checkModel("mismatch");
    checkOutput("mismatch.err_type", 64'(err_type), 64'h1);
    checkOutput("mismatch.err_idx", 64'(err_idx), 64'd2);
    checkOutput("mismatch.err_data", 64'(err_data), 64'hFF);
    checkOutput("mismatch.counts", {err_count, pkt_count}, {32'd1, 32'd1});

    // early tlast on beat 1, then a good packet
    doClear();
    sendPacket(2, -1, 0);
    sendPacket(4, -1, 1);
    tick(); tick();
    checkModel("early");
    checkOutput("early.err_type", 64'(err_type), 64'h2);
    checkOutput("early.err_idx", 64'(err_idx), 64'd1);
    checkOutput("early.counts", {err_count, pkt_count}, {32'd1, 32'd2});

    // missing tlast: 6 beats for a 4-beat packet
    doClear();
    sendPacket(6, -1, 0);
    tick(); tick();
    checkModel("missing");
    checkOutput("missing.err_type", 64'(err_type), 64'h3);
    checkOutput("missing.err_idx", 64'(err_idx), 64'd3);
    checkOutput("missing.err_data", 64'(err_data), 64'h16);
    checkOutput("missing.counts", {err_count, pkt_count}, {32'd1, 32'd1});

    // throttle 12 with continuous tvalid, wrapping ramp
    doClear();
    setCfg(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 16, 12);
    tick(); tick();
    accCount = 0;
    k = 0;
    for (int c = 0; c < 64; c++) begin
      i_tvalid = 1'b1;
      i_tdata  = cfg_ramp_start + cfg_ramp_inc * DW'(k);
      i_tlast  = (k == 15);
      if (i_tready === 1'b1) accCount++;
      if (mRdy) k++;
      tick();
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
    tick(); tick();
    checkModel("throttle");
    checkOutput("throttle.accepted", 64'(accCount), 64'd16);
    checkOutput("throttle.counts", {err_count, pkt_count}, {32'd0, 32'd1});
    checkOutput("throttle.err_flag", 64'(err_flag), 64'd0);

    // reset in the middle of a packet
    setCfg(64'h10, 64'h2, 4, 0);
    tick(); tick();
    applyStimulus(64'h10, 1'b0);
    applyStimulus(64'h12, 1'b0);
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkOutput("midreset.pkt_count", 64'(pkt_count), 64'd0);
    checkOutput("midreset.tready", 64'(i_tready), 64'd0);
    checkOutput("midreset.err_flag", 64'(err_flag), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    sendPacket(4, -1, 0);
    tick(); tick();
    checkModel("midreset");
    checkOutput("midreset.counts", {err_count, pkt_count}, {32'd0, 32'd1});

    // clear mid-packet with a simultaneous beat; trailing beats form a new packet
    doClear();
    applyStimulus(64'h10, 1'b0);
    applyStimulus(64'h12, 1'b0);
    i_tvalid = 1'b1; i_tdata = 64'hDEAD; i_tlast = 1'b0;
    doClear();
    i_tvalid = 1'b0;
    checkOutput("midclear.pkt_count", 64'(pkt_count), 64'd0);
    applyStimulus(64'h14, 1'b0);
    applyStimulus(64'h16, 1'b1);
    tick(); tick();
    checkModel("midclear");
    checkOutput("midclear.err_type", 64'(err_type), 64'h1);
    checkOutput("midclear.err_idx", 64'(err_idx), 64'd0);
    checkOutput("midclear.err_data", 64'(err_data), 64'h14);

    // randomized packets: config, length errors, corruption, gaps, clears
    doClear();
    for (int p = 0; p < 40; p++) begin
      int len;
      int nBeats;
      int badIdx;
      len = int'($urandom_range(0, 6));
      setCfg({$urandom(), $urandom()}, {$urandom(), $urandom()}, len, int'($urandom_range(0, 5)));
      nBeats = (len == 0) ? 1 : len;
      if ($urandom_range(0, 3) == 0) nBeats = int'($urandom_range(1, 8));
      badIdx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nBeats - 1)) : -1;
      if ($urandom_range(0, 9) == 0) doClear();
      sendPacket(nBeats, badIdx, 2);
      tick(); tick();
      checkModel("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/axis_ramp_checker.md
AXIS_RAMP_CHECKER -- requirements
Module: axis_ramp_checker

Interface
REQ-001 Parameter DWIDTH, default 64, SHALL set the stream data width in bits.
REQ-002 Parameter LWIDTH, default 16, SHALL set the packet-length field width in bits.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 clear  in  1  SHALL be a synchronous clear of state, counters and error capture.
REQ-006 cfg_ramp_start  in  DWIDTH  SHALL give the expected value of beat 0.
REQ-007 cfg_ramp_inc  in  DWIDTH  SHALL give the expected per-beat increment.
REQ-008 cfg_pkt_len  in  LWIDTH  SHALL give the expected beats per packet.
REQ-009 cfg_throttle  in  4  SHALL set the tready backpressure level.
REQ-010 i_tdata/i_tvalid/i_tlast  in  DWIDTH/1/1  SHALL form the AXI-Stream slave input.
REQ-011 i_tready  out  1  SHALL be the AXI-Stream ready output.
REQ-012 pkt_count  out  32  SHALL count accepted packets.
REQ-013 err_count  out  32  SHALL count packets containing at least one error.
REQ-014 pkt_done  out  1  SHALL be a one-cycle pulse per completed packet.
REQ-015 err_flag  out  1  SHALL be a sticky flag indicating an error was captured.
REQ-016 err_type  out  2  SHALL code the first error: 01 data mismatch, 10 early tlast, 11 missing tlast.
REQ-017 err_data / err_idx  out  DWIDTH/LWIDTH  SHALL hold the tdata and beat index of the first error.

Function
REQ-018 A beat SHALL be accepted only on a clk edge where i_tvalid && i_tready.
REQ-019 The 4-bit counter thr_cnt SHALL increment every cycle and wrap 15->0.
REQ-020 i_tready SHALL be registered as (thr_cnt >= cfg_throttle), independent of i_tvalid; cfg_throttle=0 gives always ready, and 15 gives 1 ready cycle in 16.
REQ-021 The FSM SHALL have three states: S_FIRST (expect beat 0), S_BODY (expect beat idx>0) and S_RESYNC (discard until tlast).
REQ-022 On a beat accepted in S_FIRST, cfg_ramp_start, cfg_ramp_inc and cfg_pkt_len SHALL be latched, with len=0 treated as 1.
REQ-023 Expected data SHALL be start + idx*inc mod 2^DWIDTH, computed by an accumulator (no multiplier), and compared against i_tdata on every accepted beat in S_FIRST/S_BODY.
REQ-024 Error detection per accepted beat: data mismatch; tlast with idx < len-1 (early); no tlast with idx == len-1 (missing).
REQ-025 When a data mismatch and a length error occur on the same beat, err_type SHALL report the data mismatch (01).
REQ-026 Transitions: on a tlast beat, any state -> S_FIRST; on an error without tlast -> S_RESYNC; on a good non-last beat -> S_BODY with idx+1.
REQ-027 In S_RESYNC, beats SHALL be consumed without checking until tlast.
REQ-028 On each accepted tlast beat: pkt_count +1; if the packet had any error, err_count +1 (once per packet); pkt_done pulses the following cycle.
REQ-029 pkt_count and err_count SHALL saturate at 0xFFFFFFFF.
REQ-030 err_flag, err_type, err_data and err_idx SHALL capture only the first error after reset/clear and hold until reset/clear.
REQ-031 When clear is asserted, it SHALL take priority over a simultaneous accepted beat; that beat is ignored.
REQ-032 A reset or clear asserted mid-packet SHALL return the FSM to S_FIRST, so trailing beats of that packet are checked as a new packet.

Reset
REQ-033 Under reset and clear: state=S_FIRST, idx=0, thr_cnt=0, i_tready=0 (reset) / per throttle next cycle, pkt_count=0, err_count=0, pkt_done=0, err_flag=0, err_type=00, err_data=0, err_idx=0.
REQ-034 i_tready SHALL first assert on the cycle after reset deasserts (cfg_throttle=0).

Verification
REQ-035 start=0x10, inc=2, len=4, throttle=0, ramp 0x10,0x12,0x14,0x16 with tlast on beat 3 -> pkt_count=1, err_count=0, pkt_done one pulse, err_flag=0.
REQ-036 Same config, beat 2 = 0xFF -> err_type=01, err_idx=2, err_data=0xFF, remaining beat discarded, err_count=1, pkt_count=1.
REQ-037 len=4, tlast on beat 1 -> err_type=10, err_idx=1; next 4-beat good packet -> pkt_count=2, err_count=1.
REQ-038 len=4, 6 beats with tlast on beat 5 -> err_type=11, err_idx=3, S_RESYNC drops beats 4-5, pkt_count=1, err_count=1.
REQ-039 throttle=12, continuous tvalid over 64 cycles -> exactly 16 accepted beats (4 per 16 cycles); inc=0xFFFF..FF with start=1 wraps to 0 with no error.
REQ-040 reset asserted after beat 1 of 4 -> outputs reset immediately; a subsequent good 4-beat packet -> pkt_count=1, err_count=0.
